// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX engine between NREQ requesters,
// with baud tick generation, inter-frame guard gap and a hung-engine watchdog.
module uart_tx_scheduler #(
    parameter int unsigned DATAWIDTH    = 8,
    parameter int unsigned NREQ         = 4,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned GAP_BITS     = 1,
    parameter int unsigned TIMEOUT      = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] req_data,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic                      err,
    output logic                      tx_start,
    output logic [DATAWIDTH-1:0]      tx_data,
    input  logic                      tx_done,
    output logic                      bit_enb,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   owner
);

    localparam int unsigned IW       = $clog2(NREQ);
    localparam int unsigned BW       = $clog2(CLKS_PER_BIT);
    localparam int unsigned WW       = $clog2(TIMEOUT + 1);
    localparam int unsigned GW       = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam int unsigned GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

    typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

    state_t               state, state_nx;
    logic [BW-1:0]        baud_cnt;
    logic [WW-1:0]        wdog;
    logic [GW-1:0]        gap_cnt;
    logic [IW-1:0]        rr, rr_nx, win_idx;
    logic [DATAWIDTH-1:0] win_data;
    logic                 win_found, grant_fire, done_fire, err_fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            baud_cnt <= '0;
        else if (baud_cnt == BW'(CLKS_PER_BIT - 1))
            baud_cnt <= '0;
        else
            baud_cnt <= baud_cnt + 1'b1;
    end

    assign bit_enb = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign busy    = (state != IDLE);
    assign rr_nx   = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

    // Winner is the first set request at or above rr, wrapping to 0.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(rr) + i;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!win_found && req[IW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (win_idx == IW'(j))
                win_data = req_data[j*DATAWIDTH +: DATAWIDTH];
        end
    end

    always_comb begin
        state_nx   = state;
        grant_fire = 1'b0;
        done_fire  = 1'b0;
        err_fire   = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_fire = 1'b1;
                    state_nx   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // tx_done takes priority over a coincident watchdog expiry
                if (tx_done) begin
                    done_fire = 1'b1;
                    state_nx  = (GAP_BITS == 0) ? IDLE : GAP;
                end else if (wdog == WW'(TIMEOUT - 1)) begin
                    err_fire = 1'b1;
                    state_nx = (GAP_BITS == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (bit_enb && gap_cnt == GW'(GAP_LAST))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            owner    <= '0;
            rr       <= '0;
            wdog     <= '0;
            gap_cnt  <= '0;
        end else begin
            gnt      <= '0;
            done     <= '0;
            err      <= 1'b0;
            tx_start <= 1'b0;
            if (grant_fire) begin
                owner    <= win_idx;
                tx_data  <= win_data;
                gnt      <= NREQ'(1) << win_idx;
                tx_start <= 1'b1;
                wdog     <= '0;
            end else if (state == WAIT_DONE) begin
                wdog <= wdog + 1'b1;
            end
            if (done_fire) begin
                done <= NREQ'(1) << owner;
                rr   <= rr_nx;
            end
            if (err_fire) begin
                err <= 1'b1;
                rr  <= rr_nx;
            end
            if (state != GAP)
                gap_cnt <= '0;
            else if (bit_enb)
                gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_uart_tx_scheduler;

    localparam int unsigned DW  = 8;
    localparam int unsigned N   = 4;
    localparam int unsigned CPB = 16;
    localparam int unsigned GB  = 1;
    localparam int unsigned TO  = 300;

    localparam int M_IDLE  = 0;
    localparam int M_FRAME = 1;
    localparam int M_GAP   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  gnt, done;
    logic          err, tx_start, tx_done, bit_enb, busy;
    logic [DW-1:0] tx_data;
    logic [1:0]    owner;

    int cyc = 0, checks = 0, errors = 0;
    int eng_cnt = 0, eng_lat = 3, rel_cyc = 0;
    bit eng_on = 0, spur_on = 0;

    typedef struct {
        logic [N-1:0] r;
        int           win;
    } vec_t;

    uart_tx_scheduler #(
        .DATAWIDTH(DW), .NREQ(N), .CLKS_PER_BIT(CPB), .GAP_BITS(GB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .done(done), .err(err), .tx_start(tx_start), .tx_data(tx_data),
        .tx_done(tx_done), .bit_enb(bit_enb), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global time limit: got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // One clock; the engine model answers tx_start after eng_lat cycles (0 = hang).
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (eng_on) begin
            tx_done = 1'b0;
            if (tx_start)
                eng_cnt = eng_lat;
            else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0)
                    tx_done = 1'b1;
            end else if (spur_on && $urandom_range(19) == 0)
                tx_done = 1'b1;
        end
    endtask

    task automatic do_reset();
        eng_on  = 0;
        spur_on = 0;
        eng_cnt = 0;
        tx_done = 1'b0;
        req     = '0;
        rst     = 1'b0;
        repeat (3) step();
        rst     = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic serve(input logic [N-1:0] r, input int win, input string nm);
        int n;
        logic [N*DW-1:0] d;
        d       = req_data;
        eng_on  = 1;
        spur_on = 0;
        eng_lat = 3;
        req     = r;
        step();
        check({nm, " gnt"}, gnt, N'(1) << win);
        check({nm, " tx_start"}, tx_start, 1);
        check({nm, " owner"}, owner, win);
        check({nm, " tx_data"}, tx_data, d[win*DW +: DW]);
        req = '0;
        n = 0;
        while (!tx_done && n < 100) begin step(); n++; end
        check({nm, " engine done seen"}, tx_done, 1);
        step();
        check({nm, " done"}, done, N'(1) << win);
        check({nm, " no err"}, err, 0);
        step();
        check({nm, " done pulse"}, done, 0);
        n = 0;
        while (busy && n < 3 * CPB * (GB + 1)) begin step(); n++; end
        check({nm, " idle after gap"}, busy, 0);
    endtask

    initial begin
        vec_t tbl[8];
        int order[5];
        int n, p, k, ts, idx, win, mode, mptr, g_cyc, gap_left;
        bit be_seen, found, flag_a, flag_b, a_td, a_be;
        logic [N-1:0] a_req, e_gnt, e_done, m_own_oh;
        logic [N*DW-1:0] a_data;
        logic [DW-1:0] m_data;
        int m_owner;
        bit e_err;

        tbl[0] = '{4'b0100, 2};
        tbl[1] = '{4'b0011, 0};
        tbl[2] = '{4'b1001, 3};
        tbl[3] = '{4'b1010, 1};
        tbl[4] = '{4'b0001, 0};
        tbl[5] = '{4'b1111, 1};
        tbl[6] = '{4'b1000, 3};
        tbl[7] = '{4'b1100, 2};
        order  = '{0, 1, 2, 3, 0};

        // Reset with all requests high
        rst      = 1'b0;
        req      = 4'b1111;
        tx_done  = 1'b0;
        req_data = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
        repeat (3) step();
        check("rst gnt", gnt, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst tx_start", tx_start, 0);
        check("rst tx_data", tx_data, 0);
        check("rst bit_enb", bit_enb, 0);
        check("rst busy", busy, 0);
        check("rst owner", owner, 0);
        req     = '0;
        rst     = 1'b1;
        rel_cyc = cyc;
        n = 0;
        while (!bit_enb && n < 3 * CPB) begin step(); n++; end
        check("baud first pulse seen", bit_enb, 1);
        step();
        p = 1;
        check("baud pulse width", bit_enb, 0);
        while (!bit_enb && p < 3 * CPB) begin step(); p++; end
        check("baud period", p, CPB);

        // Directed vector table; rr pointer evolves from 0 across the records
        do_reset();
        for (int t = 0; t < 8; t++)
            serve(tbl[t].r, tbl[t].win, $sformatf("vec%0d", t));

        // Round robin with all requests held
        do_reset();
        eng_on  = 1;
        eng_lat = 20;
        req     = 4'b1111;
        k = 0; n = 0; be_seen = 0;
        while (k < 5 && n < 1000) begin
            step();
            n++;
            if (gnt != 0) begin
                check($sformatf("rr grant %0d", k), gnt, N'(1) << order[k]);
                if (k > 0)
                    check($sformatf("rr gap tick before grant %0d", k), be_seen, 1);
                k++;
            end
            if (done != 0) be_seen = 0;
            if (bit_enb)   be_seen = 1;
        end
        check("rr grant count", k, 5);
        req = '0;

        // Timeout on requester 1, requester 2 pending
        do_reset();
        req = 4'b0010;
        step();
        check("to gnt", gnt, 4'b0010);
        ts  = cyc;
        req = 4'b0101;
        n = 0; flag_a = 0; flag_b = 0;
        while (!err && n < TO + 20) begin
            step();
            n++;
            if (done != 0) flag_a = 1;
            if (gnt != 0)  flag_b = 1;
        end
        check("to err seen", err, 1);
        check("to err latency", cyc - ts, TO);
        check("to no done", flag_a, 0);
        check("to no grant while waiting", flag_b, 0);
        step();
        check("to err pulse", err, 0);
        n = 0;
        while (gnt == 0 && n < 100) begin step(); n++; end
        check("to next grant", gnt, 4'b0100);
        req = '0;

        // tx_done on the watchdog expiry cycle
        do_reset();
        req = 4'b0001;
        step();
        check("col gnt", gnt, 4'b0001);
        ts  = cyc;
        req = '0;
        while (cyc < ts + TO - 1) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("col done", done, 4'b0001);
        check("col err", err, 0);
        step();
        check("col err late", err, 0);

        // Reset mid-frame returns rr to 0
        do_reset();
        serve(4'b0010, 1, "pre");
        eng_on  = 0;
        tx_done = 1'b0;
        req     = 4'b0100;
        step();
        check("mid gnt", gnt, 4'b0100);
        check("mid tx_data", tx_data, 8'hA5);
        req = '0;
        repeat (5) step();
        check("mid busy", busy, 1);
        rst = 1'b0;
        #1;
        check("mid rst busy", busy, 0);
        check("mid rst tx_data", tx_data, 0);
        check("mid rst owner", owner, 0);
        req = 4'b1111;
        step();
        rst     = 1'b1;
        rel_cyc = cyc;
        step();
        check("mid rr after reset", gnt, 4'b0001);
        req = '0;

        // Randomized run against the transaction-level model
        do_reset();
        eng_on   = 1;
        spur_on  = 1;
        mode     = M_IDLE;
        mptr     = 0;
        m_owner  = 0;
        m_data   = '0;
        g_cyc    = 0;
        gap_left = 0;
        for (int it = 0; it < 3000; it++) begin
            a_req  = req;
            a_data = req_data;
            a_td   = tx_done;
            a_be   = ((cyc - rel_cyc) % CPB) == CPB - 1;
            e_gnt  = '0;
            e_done = '0;
            e_err  = 0;
            if (mode == M_IDLE) begin
                if (a_req != 0) begin
                    found = 0;
                    win   = 0;
                    for (int q = 0; q < N; q++) begin
                        idx = (mptr + q) % N;
                        if (!found && a_req[idx]) begin found = 1; win = idx; end
                    end
                    e_gnt   = N'(1) << win;
                    m_owner = win;
                    m_data  = a_data[win*DW +: DW];
                    g_cyc   = cyc + 1;
                    mode    = M_FRAME;
                end
            end else if (mode == M_FRAME) begin
                if (a_td || (cyc + 1 - g_cyc == TO)) begin
                    m_own_oh = N'(1) << m_owner;
                    if (a_td) e_done = m_own_oh;
                    else      e_err  = 1;
                    mptr     = (m_owner + 1) % N;
                    gap_left = GB;
                    mode     = (GB == 0) ? M_IDLE : M_GAP;
                end
            end else if (a_be) begin
                gap_left--;
                if (gap_left == 0) mode = M_IDLE;
            end
            eng_lat = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(25, 1));
            step();
            check("rnd gnt", gnt, e_gnt);
            check("rnd tx_start", tx_start, e_gnt != 0);
            check("rnd done", done, e_done);
            check("rnd err", err, e_err);
            check("rnd busy", busy, mode != M_IDLE);
            check("rnd owner", owner, m_owner);
            check("rnd tx_data", tx_data, m_data);
            check("rnd bit_enb", bit_enb, ((cyc - rel_cyc) % CPB) == CPB - 1);
            for (int i = 0; i < N; i++) begin
                if (gnt[i])
                    req[i] = 1'b0;
                else if (!req[i] && $urandom_range(4) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*DW +: DW] = DW'($urandom);
                end else if (req[i] && $urandom_range(39) == 0)
                    req[i] = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
